// File: rtl/idx_serializer_if.sv
// Group-in / index-out handshake bundle for idx_serializer.
// slave is the serializer's view, master the producer/consumer side.
interface idx_serializer_if #(
  parameter int IDX_W = 7,
  parameter int NUM_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] idx1;
  logic [IDX_W-1:0] idx2;
  logic [IDX_W-1:0] idx3;
  logic [IDX_W-1:0] idx4;
  logic [NUM_W-1:0] num_found;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_none;
  logic             busy;

  modport slave (
    input  in_valid,
    output in_ready,
    input  idx1,
    input  idx2,
    input  idx3,
    input  idx4,
    input  num_found,
    output out_valid,
    input  out_ready,
    output out_idx,
    output out_last,
    output out_none,
    output busy
  );

  modport master (
    output in_valid,
    input  in_ready,
    output idx1,
    output idx2,
    output idx3,
    output idx4,
    output num_found,
    input  out_valid,
    output out_ready,
    input  out_idx,
    input  out_last,
    input  out_none,
    input  busy
  );
endinterface

// File: rtl/idx_serializer.sv
// Holds one group of up to MAX_NUM set-bit indices and streams them
// out one per beat, idx1 first, with valid/ready on both sides.
module idx_serializer #(
  parameter int IDX_W   = 7,
  parameter int MAX_NUM = 4,
  parameter int NUM_W   = 3
) (
  input logic          i_clk,
  input logic          i_rst_n,
  idx_serializer_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_NUM);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [NUM_W-1:0] n_q;
  logic [IDX_W-1:0] held_q [MAX_NUM];

  logic [IDX_W-1:0] in_idx [MAX_NUM];
  logic [NUM_W-1:0] n_in;
  logic             send;
  logic             last;
  logic             none;
  logic             fire;
  logic             take;

  assign in_idx[0] = bus.idx1;
  assign in_idx[1] = bus.idx2;
  assign in_idx[2] = bus.idx3;
  assign in_idx[3] = bus.idx4;

  always_comb begin
    n_in = bus.num_found;
    if (bus.num_found > NUM_W'(MAX_NUM))
      n_in = NUM_W'(MAX_NUM);
  end

  // An empty group still produces one empty-marker beat.
  assign send = (state_q == SEND);
  assign none = send && (n_q == '0);
  assign last = send &&
                ((n_q == '0) ||
                 (NUM_W'(cnt_q) == n_q - NUM_W'(1)));
  assign fire = send && bus.out_ready;

  // Accepting on the last beat keeps back-to-back groups bubble-free.
  assign bus.in_ready = !send || (last && bus.out_ready);
  assign take = bus.in_valid && bus.in_ready;

  assign bus.out_valid = send;
  assign bus.out_last  = last;
  assign bus.out_none  = none;
  assign bus.busy      = send;
  assign bus.out_idx   = (send && !none) ? held_q[cnt_q] : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      for (int i = 0; i < MAX_NUM; i++)
        held_q[i] <= '0;
    end else if (take) begin
      state_q <= SEND;
      cnt_q   <= '0;
      n_q     <= n_in;
      for (int i = 0; i < MAX_NUM; i++)
        held_q[i] <= in_idx[i];
    end else if (fire) begin
      if (last)
        state_q <= IDLE;
      else
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_idx_serializer.sv
// Scoreboard bench for idx_serializer: directed cases then random
// traffic, beats checked against a queue of expected indices.
module tb_idx_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  idx_serializer_if #(.IDX_W(7), .NUM_W(3)) bus ();

  idx_serializer #(
    .IDX_W(7),
    .MAX_NUM(4),
    .NUM_W(3)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [6:0] idx;
    logic       last;
    logic       none;
  } beat_t;

  beat_t exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_beats  = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a group expands to its first min(num,4) indices,
  // or to a single empty marker when it holds none.
  task automatic push_group(input logic [6:0] a, input logic [6:0] b,
                            input logic [6:0] c, input logic [6:0] d,
                            input logic [2:0] num);
    logic [6:0] v [4];
    int n;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    n = (num > 3'd4) ? 4 : int'(num);
    if (n == 0) exp_q.push_back('{idx: 7'd0, last: 1'b1, none: 1'b1});
    for (int i = 0; i < n; i++)
      exp_q.push_back('{idx: v[i], last: (i == n - 1), none: 1'b0});
  endtask

  task automatic step(input logic v, input logic [6:0] a,
                      input logic [6:0] b, input logic [6:0] c,
                      input logic [6:0] d, input logic [2:0] num,
                      input logic rdy, output logic hs);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.idx1      = a;
    bus.idx2      = b;
    bus.idx3      = c;
    bus.idx4      = d;
    bus.num_found = num;
    bus.out_ready = rdy;
    @(negedge clk);
    hs = bus.in_valid && bus.in_ready;
    #1;
    if (hs) push_group(a, b, c, d, num);
  endtask

  task automatic idle(input int cycles, input logic rdy);
    logic hs;
    for (int i = 0; i < cycles; i++)
      step(1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'd0, rdy, hs);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_ir;
      exp_ir = (exp_q.size() == 0) ||
               (exp_q[0].last && bus.out_ready);
      check("in_ready", 32'(bus.in_ready), 32'(exp_ir));
      check("busy", 32'(bus.busy), 32'(exp_q.size() != 0));
      check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      if (bus.out_valid && exp_q.size() != 0) begin
        check("out_idx", 32'(bus.out_idx), 32'(exp_q[0].idx));
        check("out_last", 32'(bus.out_last), 32'(exp_q[0].last));
        check("out_none", 32'(bus.out_none), 32'(exp_q[0].none));
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          n_beats++;
        end
      end
    end
  end

  initial begin
    logic hs;
    bus.in_valid  = 1'b0;
    bus.idx1      = '0;
    bus.idx2      = '0;
    bus.idx3      = '0;
    bus.idx4      = '0;
    bus.num_found = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_idx", 32'(bus.out_idx), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_busy", 32'(bus.busy), 32'd0);

    step(1'b1, 7'd3, 7'd17, 7'd64, 7'd127, 3'd4, 1'b1, hs);
    check("accept_full", 32'(hs), 32'd1);
    idle(4, 1'b1);
    check("full_drained", exp_q.size(), 0);

    step(1'b1, 7'd55, 7'd66, 7'd77, 7'd88, 3'd0, 1'b1, hs);
    check("accept_empty", 32'(hs), 32'd1);
    idle(1, 1'b1);
    check("empty_drained", exp_q.size(), 0);
    idle(1, 1'b1);

    step(1'b1, 7'd5, 7'd9, 7'd1, 7'd2, 3'd2, 1'b1, hs);
    check("b2b_accept_a", 32'(hs), 32'd1);
    step(1'b1, 7'd100, 7'd3, 7'd4, 7'd5, 3'd1, 1'b1, hs);
    check("b2b_hold", 32'(hs), 32'd0);
    step(1'b1, 7'd100, 7'd3, 7'd4, 7'd5, 3'd1, 1'b1, hs);
    check("b2b_accept_b", 32'(hs), 32'd1);
    idle(1, 1'b1);
    check("b2b_drained", exp_q.size(), 0);

    step(1'b1, 7'd5, 7'd9, 7'd0, 7'd0, 3'd2, 1'b0, hs);
    check("stall_accept", 32'(hs), 32'd1);
    idle(4, 1'b0);
    check("stall_pending", exp_q.size(), 2);
    idle(2, 1'b1);
    check("stall_drained", exp_q.size(), 0);

    step(1'b1, 7'd10, 7'd20, 7'd30, 7'd40, 3'd7, 1'b1, hs);
    check("sat_accept", 32'(hs), 32'd1);
    idle(4, 1'b1);
    check("sat_drained", exp_q.size(), 0);

    step(1'b1, 7'd11, 7'd22, 7'd33, 7'd44, 3'd4, 1'b1, hs);
    idle(1, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_idx", 32'(bus.out_idx), 32'd0);
    check("arst_last", 32'(bus.out_last), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    exp_q.delete();
    #1;
    rst_n = 1'b1;
    step(1'b1, 7'd50, 7'd60, 7'd70, 7'd80, 3'd4, 1'b1, hs);
    check("arst_next_accept", 32'(hs), 32'd1);
    idle(4, 1'b1);
    check("arst_next_drained", exp_q.size(), 0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 6),
           7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom),
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 9) < 7), hs);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      idle(1, 1'b1);
    check("final_drained", exp_q.size(), 0);
    check("beats_seen", 32'(n_beats > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
